// File: rtl/prog_loader_if.sv
// Loader bus: byte stream in from the host link, word writes out to program memory.
// Handshake: a byte transfers on every rising edge where rx_valid && rx_ready; the source holds
// rx_data/rx_valid until then, and rx_ready never depends combinationally on rx_valid.
interface prog_loader_if #(
  parameter int AW = 10
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wd;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/prog_loader.sv
// Fills program memory from a framed byte stream (A5, length, words, XOR checksum) and
// holds the CPU in reset until a frame loads cleanly.
module prog_loader #(
  parameter int AW = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  prog_loader_if.slave       bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [3:0]         dbg_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SYNC   = 4'd1,
    LEN_H  = 4'd2,
    LEN_L  = 4'd3,
    DATA_H = 4'd4,
    DATA_L = 4'd5,
    CHK    = 4'd6,
    DONE   = 4'd7,
    ERR    = 4'd8
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MAX_LEN   = 17'(1) << AW;

  state_t      state;
  logic [AW:0] len;
  logic [AW:0] cnt;
  logic [7:0]  hi;
  logic [7:0]  chk;

  logic        acc;
  logic [15:0] len_full;
  logic [AW:0] cnt_nxt;

  assign acc       = bus.rx_valid && bus.rx_ready;
  assign len_full  = {hi, bus.rx_data};
  assign cnt_nxt   = cnt + 1'b1;
  assign dbg_state = state;

  // Pure decode of the state register, so ready cannot loop back through rx_valid.
  assign bus.rx_ready = (state == SYNC)   || (state == LEN_H)  || (state == LEN_L) ||
                        (state == DATA_H) || (state == DATA_L) || (state == CHK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      len          <= '0;
      cnt          <= '0;
      hi           <= '0;
      chk          <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wd   <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SYNC;
            cnt   <= '0;
            chk   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        SYNC: begin
          if (acc && bus.rx_data == SYNC_BYTE) state <= LEN_H;
        end
        LEN_H: begin
          if (acc) begin
            hi    <= bus.rx_data;
            state <= LEN_L;
          end
        end
        LEN_L: begin
          // Full 16-bit compare so set bits above AW can never alias to a legal length.
          if (acc) begin
            len <= len_full[AW:0];
            if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA_H;
            end
          end
        end
        DATA_H: begin
          if (acc) begin
            hi    <= bus.rx_data;
            chk   <= chk ^ bus.rx_data;
            state <= DATA_L;
          end
        end
        DATA_L: begin
          if (acc) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= cnt[AW-1:0];
            bus.mem_wd   <= {hi, bus.rx_data};
            chk          <= chk ^ bus.rx_data;
            cnt          <= cnt_nxt;
            state        <= (cnt_nxt == len) ? CHK : DATA_H;
          end
        end
        CHK: begin
          if (acc) begin
            if (bus.rx_data == chk) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            state    <= SYNC;
            cnt      <= '0;
            chk      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader that fills the instruction memory read by the CPU's control unit before execution starts. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, writes them to consecutive program-memory addresses from 0, and validates the frame with an XOR checksum. It holds the CPU in reset (`cpu_hold`) from reset until a load completes without error.

## Interface
- `AW`, 10, program-memory address width; maximum program length is 2^AW words.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled in IDLE, DONE and ERR only.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte; a byte transfers on any cycle with `rx_valid && rx_ready`.
- `mem_we`  out  1  program-memory write strobe, one cycle per word.
- `mem_addr`  out  AW  write address.
- `mem_wd`  out  16  write data, {high byte, low byte}.
- `cpu_hold`  out  1  keeps the CPU in reset while 1.
- `done`  out  1  last load succeeded; level.
- `err`  out  1  last load failed; level.

## Operation
- Frame: sync byte 0xA5, length N (16 bits, high byte first), N words (high byte then low byte), checksum = XOR of all 2N data bytes. The sync and length bytes are not part of the checksum.
- States: IDLE, SYNC, LEN_H, LEN_L, DATA_H, DATA_L, CHK, DONE, ERR.
- IDLE: `start` -> SYNC. Clears word counter, checksum accumulator, `done` and `err`.
- SYNC: accepted bytes other than 0xA5 are discarded; 0xA5 -> LEN_H.
- LEN_H, LEN_L: capture N into an AW+1-bit register. If N == 0 or N > 2^AW, go to ERR after LEN_L; otherwise go to DATA_H. Compare the full 16-bit value; upper bits beyond AW+1 must be zero.
- DATA_H: latch the high byte -> DATA_L. DATA_L: on accept, issue a write of {hi, lo} at the counter address, then increment the counter. If the counter now equals N, go to CHK; else go to DATA_H.
- CHK: accepted byte equals the accumulator -> DONE; otherwise -> ERR.
- DONE: `done`=1, `cpu_hold`=0. ERR: `err`=1, `cpu_hold`=1. Completed writes are never rolled back.
- DONE/ERR: `start` -> SYNC, clearing `done` and `err` and asserting `cpu_hold` in the same transition.
- `start` in SYNC through CHK is ignored.

## Timing
- Reset values: state IDLE, `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0, `cpu_hold`=1, `done`=0, `err`=0. Counters and accumulator are 0.
- Reset mid-load aborts immediately to these values. No partial write strobe may appear after reset.
- `rx_ready` is a Moore output: 1 exactly in SYNC, LEN_H, LEN_L, DATA_H, DATA_L and CHK. There is no combinational path from `rx_valid` to `rx_ready`.
- Throughput is one byte per cycle. Gaps in `rx_valid` stall the loader with no state change.
- `mem_we`, `mem_addr` and `mem_wd` are registered. The strobe is high for exactly the one cycle following the DATA_L accept. Address and data stay stable during that cycle and hold their last values afterwards.
- `done`/`err`/`cpu_hold` update in the cycle after the CHK accept (or the LEN_L accept, for a length error).
- The `start` to `rx_ready` latency is 1 cycle.
- Counter wraps are impossible by construction, since N ≤ 2^AW is checked before any data is written. The last address written is N−1.

## Test plan
- Nominal: `start`, then bytes A5 00 02 12 34 AB CD 40 back-to-back -> writes 0x1234@0 and 0xABCD@1, then `done`=1, `cpu_hold`=0, `err`=0, `rx_ready`=0.
- Sync hunting and backpressure: bytes 00 FF 5A before the nominal frame, with `rx_valid` deasserted on alternate cycles -> identical writes and `done`; no writes before the frame.
- Bad checksum: nominal frame ending 41 -> both writes occur, then `err`=1, `done`=0, `cpu_hold`=1. A following `start` plus the nominal frame -> `done`=1, `err`=0.
- Length limits with AW=4: N=0 -> `err` after LEN_L with no writes; N=17 -> `err` with no writes; N=16 with a correct checksum -> 16 writes to addresses 0..15, then `done`.
- Reset mid-load: assert `reset` after the DATA_H byte of word 1 -> all outputs return to reset values at once, no `mem_we` pulse, and `rx_ready`=0 until the next `start`.
- `start` ignored while busy: pulse `start` during DATA_H -> the frame completes normally, with the counter and address sequence unaffected.
